// File: rtl/trackball_emu.sv
// -----------------------------------------------------------------------------
// trackball_emu
//
// Converts mouse deltas and a digital joystick into the quadrature-style
// direction/clock pairs that a LETA trackball decoder expects. Each axis keeps
// a saturating signed count of the movement it still owes. A small three-state
// machine pays that count off one step at a time, clocked by a prescaled tick.
//
// Parameters
//   CLK_DIV    clk cycles per step tick
//   ACC_W      signed width of each axis accumulator
//   JOY_PERIOD ticks between joystick injections
//   JOY_STEP   counts injected per joystick event
//
// Ports
//   clk           system clock, all state on the rising edge
//   reset_n       asynchronous active-low reset
//   mouse_strobe  one-cycle pulse, mouse_dx/mouse_dy valid
//   mouse_dx/dy   signed 9-bit deltas (two's complement)
//   joy_l/r/u/d   digital joystick, active-high
//   flip          negate both axes' contributions (cocktail player 2)
//   tbHD/tbHC     horizontal direction / clock (registered)
//   tbVD/tbVC     vertical direction / clock (registered)
// -----------------------------------------------------------------------------
module trackball_emu #(
  parameter int CLK_DIV    = 50,
  parameter int ACC_W      = 10,
  parameter int JOY_PERIOD = 400,
  parameter int JOY_STEP   = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       mouse_strobe,
  input  logic [8:0] mouse_dx,
  input  logic [8:0] mouse_dy,
  input  logic       joy_l,
  input  logic       joy_r,
  input  logic       joy_u,
  input  logic       joy_d,
  input  logic       flip,
  output logic       tbHD,
  output logic       tbHC,
  output logic       tbVD,
  output logic       tbVC
);

  localparam int PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int JW      = (JOY_PERIOD > 1) ? $clog2(JOY_PERIOD) : 1;
  // Symmetric clamp: the most negative two's complement code is never used.
  localparam int ACC_MAX = (1 << (ACC_W - 1)) - 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_HIGH  = 2'd2
  } axis_state_e;

  // ---------------------------------------------------------------------------
  // Step-tick prescaler
  // ---------------------------------------------------------------------------
  logic [PW-1:0] pre_q, pre_d;
  logic          tick;

  assign tick  = (pre_q == PW'(CLK_DIV - 1));
  assign pre_d = tick ? '0 : pre_q + PW'(1);

  // ---------------------------------------------------------------------------
  // Joystick period counter, advanced on ticks only. joy_evt is the single
  // cycle on which it wraps; that is the only cycle joystick steps are added.
  // ---------------------------------------------------------------------------
  logic [JW-1:0] joy_cnt_q, joy_cnt_d;
  logic          joy_evt;

  assign joy_evt = tick && (joy_cnt_q == JW'(JOY_PERIOD - 1));

  always_comb begin
    joy_cnt_d = joy_cnt_q;
    if (tick) begin
      joy_cnt_d = joy_evt ? '0 : joy_cnt_q + JW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_q     <= '0;
      joy_cnt_q <= '0;
    end else begin
      pre_q     <= pre_d;
      joy_cnt_q <= joy_cnt_d;
    end
  end

  // Axis 0 = horizontal, axis 1 = vertical.
  logic [1:0][8:0] delta;
  logic [1:0]      joy_pos;
  logic [1:0]      joy_neg;

  assign delta   = {mouse_dy, mouse_dx};
  assign joy_pos = {joy_u, joy_r};
  assign joy_neg = {joy_d, joy_l};

  // ---------------------------------------------------------------------------
  // Per-axis accumulator and pulse FSM
  // ---------------------------------------------------------------------------
  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_axis
    axis_state_e             state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    xd_q, xd_d;   // latched direction, also the D output
    logic                    xc_q, xc_d;
    logic                    leave_setup;
    logic signed [31:0]      m_term, j_term, s_term, sum;

    // Pulse FSM. Direction is captured on IDLE exit and not revisited until
    // the pulse finishes, so a sign change mid-pulse cannot corrupt it and D
    // is settled a full tick before the clock rises.
    always_comb begin
      state_d     = state_q;
      xd_d        = xd_q;
      xc_d        = xc_q;
      leave_setup = 1'b0;
      if (tick) begin
        case (state_q)
          ST_IDLE: begin
            xc_d = 1'b0;
            if (acc_q != '0) begin
              xd_d    = ~acc_q[ACC_W-1];
              state_d = ST_SETUP;
            end
          end
          ST_SETUP: begin
            xc_d        = 1'b1;
            leave_setup = 1'b1;
            state_d     = ST_HIGH;
          end
          ST_HIGH: begin
            xc_d    = 1'b0;
            state_d = ST_IDLE;
          end
          default: begin
            xc_d    = 1'b0;
            state_d = ST_IDLE;
          end
        endcase
      end
    end

    // Accumulator update. Mouse, joystick and the count being paid off all
    // land in one sum so that coincident events are never lost; the sum is
    // wide enough that clamping happens only once, after everything is added.
    always_comb begin
      m_term = '0;
      if (mouse_strobe) begin
        m_term = 32'($signed(delta[gi]));
      end
      if (flip) begin
        m_term = -m_term;
      end

      j_term = '0;
      if (joy_evt && (joy_pos[gi] != joy_neg[gi])) begin
        j_term = joy_pos[gi] ? JOY_STEP : -JOY_STEP;
      end
      if (flip) begin
        j_term = -j_term;
      end

      s_term = '0;
      if (leave_setup) begin
        s_term = xd_q ? 32'sd1 : -32'sd1;
      end

      sum = 32'(acc_q) + m_term + j_term - s_term;

      if (sum > ACC_MAX) begin
        acc_d = ACC_W'(ACC_MAX);
      end else if (sum < -ACC_MAX) begin
        acc_d = ACC_W'(-ACC_MAX);
      end else begin
        acc_d = sum[ACC_W-1:0];
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_q <= ST_IDLE;
        acc_q   <= '0;
        xd_q    <= 1'b0;
        xc_q    <= 1'b0;
      end else begin
        state_q <= state_d;
        acc_q   <= acc_d;
        xd_q    <= xd_d;
        xc_q    <= xc_d;
      end
    end
  end

  assign tbHD = g_axis[0].xd_q;
  assign tbHC = g_axis[0].xc_q;
  assign tbVD = g_axis[1].xd_q;
  assign tbVC = g_axis[1].xc_q;

endmodule
